ex_div: RTL

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_pkg.sv | 34 +++
 rtl/ex_div.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ex_div_pkg.sv
// Shared definitions for the execute-stage divider: op encodings,
// FSM state encoding and small operand helpers.
package ex_div_pkg;

    // Op encodings shared with the decoder and the execute stage.
    // Bit 1 selects the remainder, bit 0 selects unsigned.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int XLEN      = 32;
    localparam int CALC_CYCS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

    // Magnitude of an operand; unsigned ops pass through untouched.
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the execute stage.
// Radix-2 restoring division, one quotient bit per cycle, with
// divide-by-zero and signed-overflow results produced without iterating.
module ex_div
    import ex_div_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [4:0]  rd_addr_in,
    input  logic        flush,
    output logic        hold_req,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_addr_out
);

    div_state_e  state;
    logic [1:0]  op_r;
    logic [31:0] dividend_r;
    logic [31:0] divisor_r;
    logic [4:0]  rd_r;
    logic [5:0]  cnt;
    // {partial remainder, dividend bits being shifted out / quotient bits shifted in}
    logic [63:0] acc;

    logic        accept;
    logic        in_div_zero;
    logic        in_overflow;
    logic        in_special;
    logic [31:0] special_res;
    logic [31:0] dsr_mag;
    logic [32:0] trial;
    logic [63:0] acc_next;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] final_res;

    assign accept = (state == ST_IDLE) && start && !flush;

    // Special cases are decided on the raw operands at start time.
    assign in_div_zero = (divisor == 32'h0);
    assign in_overflow = op_is_signed(op) && (dividend == 32'h8000_0000) &&
                         (divisor == 32'hFFFF_FFFF);
    assign in_special  = in_div_zero || in_overflow;

    always_comb begin
        special_res = 32'h0;
        if (op_is_rem(op))
            special_res = in_div_zero ? dividend : 32'h0;
        else
            special_res = in_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    // One restoring step: trial-subtract the divisor from the shifted remainder.
    // Bit 32 of the 33-bit difference is the borrow, i.e. "does not fit".
    assign dsr_mag = mag32(divisor_r, op_is_signed(op_r));
    assign trial   = acc[63:31] - {1'b0, dsr_mag};

    always_comb begin
        acc_next = {acc[62:0], 1'b0};
        if (!trial[32])
            acc_next = {trial[31:0], acc[30:0], 1'b1};
    end

    // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
    assign neg_q = op_is_signed(op_r) && (dividend_r[31] ^ divisor_r[31]);
    assign neg_r = op_is_signed(op_r) && dividend_r[31];

    always_comb begin
        final_res = 32'h0;
        if (op_is_rem(op_r))
            final_res = neg_r ? (~acc_next[63:32] + 1'b1) : acc_next[63:32];
        else
            final_res = neg_q ? (~acc_next[31:0] + 1'b1) : acc_next[31:0];
    end

    // Control FSM, operand capture, iteration and result register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            op_r        <= 2'b00;
            dividend_r  <= 32'h0;
            divisor_r   <= 32'h0;
            rd_r        <= 5'h0;
            cnt         <= 6'h0;
            acc         <= 64'h0;
            result      <= 32'h0;
            rd_addr_out <= 5'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r       <= op;
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        rd_r       <= rd_addr_in;
                        cnt        <= 6'h0;
                        if (in_special) begin
                            acc         <= 64'h0;
                            result      <= special_res;
                            rd_addr_out <= rd_addr_in;
                            state       <= ST_DONE;
                        end else begin
                            acc   <= {32'h0, mag32(dividend, op_is_signed(op))};
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(CALC_CYCS - 1)) begin
                            result      <= final_res;
                            rd_addr_out <= rd_r;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs; a flush in CALC/DONE kills the stall and write-back at once.
    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE) && !flush;
    assign hold_req     = accept || ((state == ST_CALC) && !flush);

endmodule
